icache_assoc: RTL and testbench
===============================

Name: icache_assoc

Overview:
- Parametrised N-way set-associative instruction cache sitting between the IFU fetch address and the AXI read master port.
- Generalises the direct-mapped icache in three ways: configurable associativity with per-set round-robin replacement, a latched miss context, and bus-error handling.
- Refills are critical-word-first WRAP bursts.
- Supports fence.i invalidation.

Parameters:
- OFFSET_W, 4, log2 line bytes (line = 2^OFFSET_W bytes); must be >= 3.
- INDEX_W, 6, log2 number of sets.
- WAYS, 2, associativity; power of two, 1..8.
- TAG_W, 32-OFFSET_W-INDEX_W, tag width (derived).
- WORDS, 2^(OFFSET_W-2), 32-bit words per line (derived).

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- fencei  in  1  one-cycle pulse; invalidate all lines.
- addr  in  32  fetch address, word aligned.
- hit  out  1  addr hits a valid line this cycle (combinational).
- inst  out  32  instruction word for addr; valid only when hit=1.
- err  out  1  one-cycle pulse: the refill returned a non-OKAY rresp.
- arvalid  out  1  AXI AR valid.
- arready  in  1  AXI AR ready.
- araddr  out  32  AXI AR address.
- arid  out  4  constant 0.
- arlen  out  8  constant WORDS-1.
- arsize  out  3  constant 3'b010.
- arburst  out  2  2'b10 (WRAP); 2'b00 if WORDS==1.
- rvalid  in  1  AXI R valid.
- rready  out  1  AXI R ready.
- rdata  in  64  AXI R data.
- rresp  in  2  AXI R response.
- rlast  in  1  AXI R last.

Behaviour:
- Address split:
  - tag = addr[31:OFFSET_W+INDEX_W]
  - index = addr[OFFSET_W+INDEX_W-1:OFFSET_W]
  - off = addr[OFFSET_W-1:2]
- Hit:
  - hit = OR over ways of (valid[w][index] & tag[w][index]==tag).
  - inst = data of the hitting way at word off.
  - At most one way may match; a multi-match is an assertion failure in simulation.
- Reset (async, reset_n=0):
  - state=IDLE, all valid bits=0, all round-robin pointers=0, err=0, arvalid=0, rready=0.
  - Data and tag arrays are not reset.
  - A reset mid-burst abandons the fill; no line is validated.
- FSM states:
  - IDLE:
    - On !hit, latch miss_tag, miss_index and miss_off from addr; latch victim; go to REQ.
    - Victim = lowest-numbered invalid way in the set, else rr_ptr[index].
  - REQ:
    - arvalid=1, araddr={miss_tag,miss_index,miss_off,2'b00}.
    - On arready go to RESP. araddr stays stable while arvalid=1.
  - RESP:
    - rready=1.
    - Each rvalid beat writes word fill_off into the victim way; fill_off starts at miss_off and increments mod WORDS.
    - Word select: rdata[63:32] if fill_off[0]=1, else rdata[31:0].
    - On the rlast beat go to IDLE.
    - If no beat of the burst had rresp!=0: set valid and tag for the victim, and advance rr_ptr[miss_index] mod WAYS.
    - If any beat of the burst had rresp!=0: leave the line invalid, leave rr_ptr unchanged, and pulse err in the cycle after the rlast beat.
- Latency:
  - Hit: 0 cycles (combinational).
  - Miss: hit rises the cycle after the rlast beat, provided addr is unchanged.
- addr may change during REQ/RESP. The fill uses only the latched context. hit reflects the current addr against array contents, so a hit to another line during a fill is legal.
- fencei:
  - Clears all valid bits at the next clock edge.
  - If it coincides with an error-free rlast beat, the line being filled is still validated (new-fill priority).
  - During REQ/RESP the burst completes normally.
  - rr_ptr is not cleared.
- A miss on the same set as the in-flight fill cannot be issued; the FSM only accepts misses in IDLE.

Optional Feature:
- ICACHE_PERF_EN:
  - When defined, adds outputs perf_hit_cnt[31:0] and perf_miss_cnt[31:0], both reset to 0 and wrapping at 2^32.
  - perf_hit_cnt increments on each IDLE cycle with hit=1.
  - perf_miss_cnt increments on each AR handshake.
  - When undefined, these ports and counters are absent; functional behaviour is identical.

Test Plan:
- Cold miss, defaults: addr=0x8000_0008 after reset -> arvalid=1, araddr=0x8000_0008, arlen=3, arburst=2'b10. Beats carry words 2,3,0,1 with rlast on the fourth. Next cycle hit=1, inst=word 2; addr=0x8000_0000 then hits with word 0.
- Associativity: fill 0x8000_0000, then 0x8000_0400 (same index 0, different tag) -> both hit afterwards. A third tag 0x8000_0800 evicts way 0 (rr_ptr=0) -> 0x8000_0000 misses, 0x8000_0400 still hits.
- Bus error: rresp=2'b10 on beat 2 of a fill -> err pulses for 1 cycle after rlast, hit stays 0, the next cycle re-issues AR with the same araddr.
- fence.i: with 2 valid lines, pulse fencei -> next cycle both miss. fencei coincident with an error-free rlast beat -> the filled line hits, the other line misses.
- Async reset mid-burst: drop reset_n after 2 beats -> arvalid=0, rready=0, err=0 immediately; after release the same addr misses and re-issues AR.
- Addr change during fill: change addr to a resident line mid-RESP -> hit=1 immediately; the fill still completes into the latched set/tag.

Source files
------------

// File: rtl/icache_assoc.sv
// icache_assoc: N-way set-associative I-cache, round-robin replacement, critical-word-first WRAP refill.
// Optional `ICACHE_PERF_EN adds perf_hit_cnt / perf_miss_cnt outputs.
module icache_assoc #(
    parameter int OFFSET_W = 4,
    parameter int INDEX_W  = 6,
    parameter int WAYS     = 2,
    parameter int TAG_W    = 32 - OFFSET_W - INDEX_W,
    parameter int WORDS    = 2 ** (OFFSET_W - 2)
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        fencei,
    input  logic [31:0] addr,
    output logic        hit,
    output logic [31:0] inst,
    output logic        err,
    output logic        arvalid,
    input  logic        arready,
    output logic [31:0] araddr,
    output logic [3:0]  arid,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    input  logic        rvalid,
    output logic        rready,
    input  logic [63:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] perf_hit_cnt,
    output logic [31:0] perf_miss_cnt
`endif
);
    localparam int SETS = 2 ** INDEX_W;
    localparam int OW   = OFFSET_W - 2;
    localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t                      state_q;
    logic [TAG_W-1:0]            tag_q  [WAYS][SETS];
    logic [31:0]                 data_q [WAYS][SETS][WORDS];
    logic [WAYS-1:0][SETS-1:0]   valid_q;
    logic [SETS-1:0][WW-1:0]     rr_q;
    logic [TAG_W-1:0]            miss_tag_q;
    logic [INDEX_W-1:0]          miss_idx_q;
    logic [OW-1:0]               miss_off_q, fill_off_q;
    logic [WW-1:0]               vic_q;
    logic                        bad_q, err_q, arvalid_q, rready_q;

    logic [TAG_W-1:0]   tag_a;
    logic [INDEX_W-1:0] idx_a;
    logic [OW-1:0]      off_a;
    logic [WAYS-1:0]    match;
    logic [WW-1:0]      victim;
    logic               unused_addr;

    assign tag_a       = addr[31:OFFSET_W+INDEX_W];
    assign idx_a       = addr[OFFSET_W+INDEX_W-1:OFFSET_W];
    assign off_a       = addr[OFFSET_W-1:2];
    assign unused_addr = ^addr[1:0];

    // Descending scan leaves the lowest-numbered invalid way as the victim.
    always_comb begin
        match  = '0;
        inst   = '0;
        victim = rr_q[idx_a];
        for (int w = WAYS - 1; w >= 0; w--) begin
            match[w] = valid_q[w][idx_a] && tag_q[w][idx_a] == tag_a;
            inst     = match[w] ? data_q[w][idx_a][off_a] : inst;
            victim   = valid_q[w][idx_a] ? victim : WW'(w);
        end
        hit = |match;
    end

    assign arvalid = arvalid_q;
    assign rready  = rready_q;
    assign err     = err_q;
    assign araddr  = {miss_tag_q, miss_idx_q, miss_off_q, 2'b00};
    assign arid    = 4'd0;
    assign arlen   = 8'(WORDS - 1);
    assign arsize  = 3'b010;
    assign arburst = (WORDS == 1) ? 2'b00 : 2'b10;

    always_ff @(posedge clock) begin
        if (state_q == RESP && rvalid) begin
            data_q[vic_q][miss_idx_q][fill_off_q] <= fill_off_q[0] ? rdata[63:32] : rdata[31:0];
            tag_q[vic_q][miss_idx_q]              <= miss_tag_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            rr_q       <= '0;
            err_q      <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            bad_q      <= 1'b0;
            miss_tag_q <= '0;
            miss_idx_q <= '0;
            miss_off_q <= '0;
            fill_off_q <= '0;
            vic_q      <= '0;
`ifdef ICACHE_PERF_EN
            perf_hit_cnt  <= '0;
            perf_miss_cnt <= '0;
`endif
        end else begin
            err_q <= 1'b0;
            if (fencei)
                valid_q <= '0;
`ifdef ICACHE_PERF_EN
            if (state_q == IDLE && hit)
                perf_hit_cnt <= perf_hit_cnt + 32'd1;
            if (arvalid_q && arready)
                perf_miss_cnt <= perf_miss_cnt + 32'd1;
`endif
            case (state_q)
                IDLE: if (!hit) begin
                    miss_tag_q <= tag_a;
                    miss_idx_q <= idx_a;
                    miss_off_q <= off_a;
                    fill_off_q <= off_a;
                    vic_q      <= victim;
                    bad_q      <= 1'b0;
                    arvalid_q  <= 1'b1;
                    // The victim's words are overwritten during the burst, so it must stop hitting now.
                    valid_q[victim][idx_a] <= 1'b0;
                    state_q    <= REQ;
                end
                REQ: if (arready) begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b1;
                    state_q   <= RESP;
                end
                RESP: if (rvalid) begin
                    fill_off_q <= fill_off_q + OW'(1);
                    bad_q      <= bad_q | (rresp != 2'b00);
                    if (rlast) begin
                        rready_q <= 1'b0;
                        state_q  <= IDLE;
                        if (bad_q || rresp != 2'b00)
                            err_q <= 1'b1;
                        else begin
                            valid_q[vic_q][miss_idx_q] <= 1'b1;
                            rr_q[miss_idx_q] <= WW'((int'(rr_q[miss_idx_q]) + 1) % WAYS);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assert property (@(posedge clock) disable iff (!reset_n) $onehot0(match));

endmodule

// File: tb/tb_icache_assoc.sv
// tb_icache_assoc: directed + randomized fetches against a line-level cache model and a modelled AXI memory.
module tb_icache_assoc;
    localparam int OW = 4, IW = 6, WAYS = 2, WORDS = 4, SETS = 64;

    logic        clock = 1'b0, reset_n = 1'b0, fencei = 1'b0, arready = 1'b0;
    logic        rvalid = 1'b0, rlast = 1'b0;
    logic [31:0] addr = 32'h8000_0008;
    logic [63:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        hit, err, arvalid, rready;
    logic [31:0] inst, araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;

    always #5 clock = ~clock;

    icache_assoc dut (
        .clock(clock), .reset_n(reset_n), .fencei(fencei), .addr(addr), .hit(hit), .inst(inst),
        .err(err), .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst), .rvalid(rvalid), .rready(rready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast)
    );

    int          n_cmp = 0, n_bad = 0;
    bit          m_valid [WAYS][SETS];
    logic [31:0] m_tag   [WAYS][SETS];
    int          m_rr    [SETS];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0F1E_2D3C;
    endfunction

    function automatic int set_of(input logic [31:0] a);
        return int'((a >> OW) % SETS);
    endfunction

    function automatic int m_way(input logic [31:0] a);
        for (int w = 0; w < WAYS; w++)
            if (m_valid[w][set_of(a)] && m_tag[w][set_of(a)] == (a >> (OW + IW)))
                return w;
        return -1;
    endfunction

    task automatic m_clear(input bit rr_too);
        for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++)
                m_valid[w][s] = 1'b0;
        if (rr_too)
            for (int s = 0; s < SETS; s++)
                m_rr[s] = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic finish_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    endtask

    task automatic expect_lookup(input string tag, input logic [31:0] a);
        int w = m_way(a);
        chk({tag, "_hit"}, 32'(hit), 32'(w >= 0));
        if (w >= 0)
            chk({tag, "_inst"}, inst, mem_word(a));
    endtask

    task automatic access(input logic [31:0] a, input int bad_beat, input bit fence_last,
                          input int abort_after, input logic [31:0] alt);
        int s = set_of(a), vic, fo;
        bit bad;
        logic [31:0] wa;
        @(negedge clock);
        addr = a;
        #1;
        expect_lookup("lookup", a);
        if (m_way(a) >= 0)
            return;
        forever begin
            vic = -1;
            for (int w = 0; w < WAYS; w++)
                if (!m_valid[w][s]) begin
                    vic = w;
                    break;
                end
            if (vic < 0)
                vic = m_rr[s];
            m_valid[vic][s] = 1'b0;
            for (int i = 0; i < 8 && !arvalid; i++)
                @(negedge clock);
            chk("ar_wait", 32'(arvalid), 32'd1);
            if (!arvalid)
                finish_run();
            chk("araddr", araddr, a);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clock);
                chk("ar_hold", {araddr[30:0], arvalid}, {a[30:0], 1'b1});
            end
            arready = 1'b1;
            @(negedge clock);
            arready = 1'b0;
            chk("ar_done", {arvalid, rready}, 2'b01);
            fo  = int'((a >> 2) % WORDS);
            bad = 1'b0;
            for (int b = 0; b < WORDS; b++) begin
                repeat ($urandom_range(0, 2)) @(negedge clock);
                if (b == abort_after) begin
                    reset_n = 1'b0;
                    #1;
                    chk("rst_mid", {arvalid, rready, err, hit}, 4'b0000);
                    m_clear(1'b1);
                    @(negedge clock);
                    reset_n = 1'b1;
                    return;
                end
                wa     = (a & ~32'(WORDS * 4 - 1)) | 32'(fo << 2);
                rdata  = fo[0] ? {mem_word(wa), 32'($urandom())} : {32'($urandom()), mem_word(wa)};
                rresp  = (b == bad_beat) ? 2'b10 : 2'b00;
                bad    = bad | (b == bad_beat);
                rlast  = (b == WORDS - 1);
                rvalid = 1'b1;
                fencei = fence_last && rlast;
                if (b == 1 && alt != a) begin
                    addr = alt;
                    #1;
                    expect_lookup("alt", alt);
                end
                @(negedge clock);
                {rvalid, rlast, rresp, fencei} = '0;
                addr = a;
                fo   = (fo + 1) % WORDS;
            end
            if (fence_last)
                m_clear(1'b0);
            chk("err", 32'(err), 32'(bad));
            if (!bad) begin
                m_valid[vic][s] = 1'b1;
                m_tag[vic][s]   = a >> (OW + IW);
                m_rr[s]         = (m_rr[s] + 1) % WAYS;
            end
            #1;
            expect_lookup("fill", a);
            if (!bad)
                return;
            bad_beat   = -1;
            fence_last = 1'b0;
            alt        = a;
            @(negedge clock);
            chk("err_pulse", {err, arvalid}, 2'b01);
            chk("reissue", araddr, a);
        end
    endtask

    task automatic fetch(input logic [31:0] a);
        access(a, -1, 1'b0, -1, a);
    endtask

    task automatic fence_pulse();
        @(negedge clock);
        fencei = 1'b1;
        @(negedge clock);
        fencei = 1'b0;
        m_clear(1'b0);
        #1;
        expect_lookup("fence", addr);
    endtask

    initial begin
        #1_000_000;
        n_bad++;
        $display("FAIL watchdog: run did not complete");
        finish_run();
    end

    initial begin
        logic [31:0] a;
        m_clear(1'b1);
        #12;
        chk("reset", {arvalid, rready, err, hit}, 4'b0000);
        chk("ar_const", {arid, arlen, arsize, arburst}, {4'd0, 8'd3, 3'b010, 2'b10});
        @(negedge clock);
        reset_n = 1'b1;
        fetch(32'h8000_0008);
        fetch(32'h8000_0000);
        fetch(32'h8000_000C);
        fetch(32'h8000_0400);
        fetch(32'h8000_0000);
        fetch(32'h8000_0404);
        fetch(32'h8000_0800);
        fetch(32'h8000_0400);
        fetch(32'h8000_0000);
        access(32'h8000_0020, 1, 1'b0, -1, 32'h8000_0020);
        fetch(32'h8000_0404);
        access(32'h8000_0044, -1, 1'b0, -1, 32'h8000_0404);
        fetch(32'h8000_0100);
        fetch(32'h8000_0200);
        fence_pulse();
        addr = 32'h8000_0100;
        #1;
        expect_lookup("fence_other", 32'h8000_0100);
        fetch(32'h8000_0100);
        fetch(32'h8000_0200);
        access(32'h8000_0300, -1, 1'b1, -1, 32'h8000_0300);
        fetch(32'h8000_0100);
        fetch(32'h8000_0200);
        access(32'h8000_0050, -1, 1'b0, 2, 32'h8000_0050);
        fetch(32'h8000_0050);
        for (int i = 0; i < 200; i++) begin
            a = 32'h8000_0000 | 32'($urandom_range(0, 2) << 10) | 32'($urandom_range(0, 3) << 4)
                | 32'($urandom_range(0, 3) << 2);
            access(a, ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, WORDS - 1)) : -1,
                   $urandom_range(0, 9) == 0, -1,
                   32'h8000_0000 | 32'($urandom_range(0, 2) << 10) | 32'($urandom_range(0, 3) << 4));
            if ($urandom_range(0, 15) == 0) begin
                fence_pulse();
                fetch(addr);
            end
        end
        finish_run();
    end
endmodule
